// File: rtl/pci_dac_initiator.sv
// PCI bus-master initiator for memory read/write bursts of 1..MAX_LEN DWORDs,
// issuing a Dual Address Cycle whenever the upper 32 address bits are non-zero.
module pci_dac_initiator #(
    parameter int DEVSEL_TIMEOUT = 5,
    parameter int MAX_LEN        = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [63:0]  req_addr,
    input  logic [2:0]   req_len,
    input  logic [127:0] req_wdata,
    input  logic [3:0]   req_be,
    output logic [31:0]  rd_data,
    output logic         rd_valid,
    output logic         done,
    output logic [1:0]   status,
    output logic [2:0]   xfer_cnt,
    output logic         FRAMEn,
    output logic         IRDYn,
    output logic [3:0]   C_BEn,
    inout  wire  [31:0]  AD,
    input  logic         TRDYn,
    input  logic         STOPn,
    input  logic         DEVSELn
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR_LO, S_ADDR_HI, S_TURN, S_DATA, S_ABORT, S_END
    } state_t;

    localparam logic [3:0] CMD_DAC = 4'b1101;
    localparam logic [3:0] CMD_RD  = 4'b0110;
    localparam logic [3:0] CMD_WR  = 4'b0111;
    localparam logic [7:0] TMO_LAST = 8'(DEVSEL_TIMEOUT - 1);

    state_t         state_r, state_s;
    logic [31:0]    addr_hi_r;
    logic           write_r;
    logic [2:0]     len_r;
    logic [127:0]   wdata_r;
    logic [3:0]     be_r;
    logic [2:0]     cnt_r, cnt_s;
    logic           seen_r, seen_s;
    logic [7:0]     timer_r, timer_s;
    logic [1:0]     term_r, term_s;
    logic           accept_s;

    logic           ready_r, ready_s;
    logic           frame_r, frame_s;
    logic           irdy_r, irdy_s;
    logic [3:0]     cbe_r, cbe_s;
    logic [31:0]    ad_out_r, ad_s;
    logic           oe_r, oe_s;
    logic [31:0]    rd_data_r, rd_data_s;
    logic           rd_valid_r, rd_valid_s;
    logic           done_r, done_s;
    logic [1:0]     status_r, status_s;
    logic [2:0]     xfer_r, xfer_s;

    function automatic logic [31:0] dword(input logic [127:0] d, input logic [1:0] k);
        case (k)
            2'd0:    return d[31:0];
            2'd1:    return d[63:32];
            2'd2:    return d[95:64];
            default: return d[127:96];
        endcase
    endfunction

    // Next state and next registered bus/handshake values
    always_comb begin
        state_s    = state_r;
        ready_s    = 1'b0;
        frame_s    = 1'b1;
        irdy_s     = 1'b1;
        cbe_s      = 4'hF;
        ad_s       = ad_out_r;
        oe_s       = 1'b0;
        rd_data_s  = rd_data_r;
        rd_valid_s = 1'b0;
        done_s     = 1'b0;
        status_s   = status_r;
        xfer_s     = xfer_r;
        cnt_s      = cnt_r;
        seen_s     = seen_r;
        timer_s    = timer_r;
        term_s     = term_r;
        accept_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_valid && ready_r) begin
                    accept_s = 1'b1;
                    cnt_s    = 3'd0;
                    seen_s   = 1'b0;
                    timer_s  = 8'd0;
                    term_s   = 2'd0;
                    if (req_len == 3'd0 || req_len > 3'(MAX_LEN)) begin
                        state_s  = S_END;
                        done_s   = 1'b1;
                        status_s = 2'd3;
                        xfer_s   = 3'd0;
                    end else begin
                        frame_s = 1'b0;
                        oe_s    = 1'b1;
                        ad_s    = req_addr[31:0] & 32'hFFFF_FFFC;
                        if (req_addr[63:32] != 32'd0) begin
                            state_s = S_ADDR_LO;
                            cbe_s   = CMD_DAC;
                        end else begin
                            state_s = S_ADDR_HI;
                            cbe_s   = req_write ? CMD_WR : CMD_RD;
                        end
                    end
                end else begin
                    ready_s = 1'b1;
                end
            end
            S_ADDR_LO: begin
                state_s = S_ADDR_HI;
                frame_s = 1'b0;
                oe_s    = 1'b1;
                ad_s    = addr_hi_r;
                cbe_s   = write_r ? CMD_WR : CMD_RD;
            end
            S_ADDR_HI: begin
                irdy_s  = 1'b0;
                cbe_s   = be_r;
                timer_s = 8'd0;
                seen_s  = 1'b0;
                if (write_r) begin
                    state_s = S_DATA;
                    frame_s = (len_r == 3'd1);
                    oe_s    = 1'b1;
                    ad_s    = dword(wdata_r, 2'd0);
                end else begin
                    state_s = S_TURN;
                    frame_s = 1'b0;
                end
            end
            S_TURN: begin
                seen_s = seen_r | ~DEVSELn;
                irdy_s = 1'b0;
                cbe_s  = be_r;
                if (!seen_s && timer_r == TMO_LAST) begin
                    state_s = S_ABORT;
                    term_s  = 2'd2;
                end else begin
                    timer_s = seen_s ? timer_r : timer_r + 8'd1;
                    state_s = S_DATA;
                    frame_s = (len_r == 3'd1);
                end
            end
            S_DATA: begin
                seen_s  = seen_r | ~DEVSELn;
                irdy_s  = 1'b0;
                cbe_s   = be_r;
                frame_s = frame_r;
                oe_s    = oe_r;
                if (!TRDYn) begin
                    cnt_s = cnt_r + 3'd1;
                    if (!write_r) begin
                        rd_data_s  = AD;
                        rd_valid_s = 1'b1;
                    end else begin
                        rd_data_s  = rd_data_r;
                    end
                    if (cnt_s == len_r) begin
                        state_s  = S_END;
                        done_s   = 1'b1;
                        status_s = 2'd0;
                        xfer_s   = cnt_s;
                        frame_s  = 1'b1;
                        irdy_s   = 1'b1;
                        cbe_s    = 4'hF;
                        oe_s     = 1'b0;
                    end else if (!STOPn) begin
                        state_s = S_ABORT;
                        term_s  = 2'd1;
                        frame_s = 1'b1;
                    end else begin
                        frame_s = (cnt_s == len_r - 3'd1);
                        ad_s    = dword(wdata_r, cnt_s[1:0]);
                    end
                end else if (!STOPn) begin
                    state_s = S_ABORT;
                    term_s  = 2'd1;
                    frame_s = 1'b1;
                end else if (!seen_s && timer_r == TMO_LAST) begin
                    state_s = S_ABORT;
                    term_s  = 2'd2;
                    frame_s = 1'b1;
                end else begin
                    timer_s = seen_s ? timer_r : timer_r + 8'd1;
                end
            end
            S_ABORT: begin
                // FRAMEn is already high here; IRDYn is released on the way to END
                state_s  = S_END;
                done_s   = 1'b1;
                status_s = term_r;
                xfer_s   = (term_r == 2'd2) ? 3'd0 : cnt_r;
            end
            S_END: begin
                state_s = S_IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Request capture on acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_hi_r <= 32'd0;
            write_r   <= 1'b0;
            len_r     <= 3'd0;
            wdata_r   <= 128'd0;
            be_r      <= 4'hF;
        end else if (accept_s) begin
            addr_hi_r <= req_addr[63:32];
            write_r   <= req_write;
            len_r     <= req_len;
            wdata_r   <= req_wdata;
            be_r      <= req_be;
        end
    end

    // State, counters and all registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= S_IDLE;
            cnt_r      <= 3'd0;
            seen_r     <= 1'b0;
            timer_r    <= 8'd0;
            term_r     <= 2'd0;
            ready_r    <= 1'b0;
            frame_r    <= 1'b1;
            irdy_r     <= 1'b1;
            cbe_r      <= 4'hF;
            ad_out_r   <= 32'd0;
            oe_r       <= 1'b0;
            rd_data_r  <= 32'd0;
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            status_r   <= 2'd0;
            xfer_r     <= 3'd0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            seen_r     <= seen_s;
            timer_r    <= timer_s;
            term_r     <= term_s;
            ready_r    <= ready_s;
            frame_r    <= frame_s;
            irdy_r     <= irdy_s;
            cbe_r      <= cbe_s;
            ad_out_r   <= ad_s;
            oe_r       <= oe_s;
            rd_data_r  <= rd_data_s;
            rd_valid_r <= rd_valid_s;
            done_r     <= done_s;
            status_r   <= status_s;
            xfer_r     <= xfer_s;
        end
    end

    assign AD        = oe_r ? ad_out_r : 32'bz;
    assign req_ready = ready_r;
    assign FRAMEn    = frame_r;
    assign IRDYn     = irdy_r;
    assign C_BEn     = cbe_r;
    assign rd_data   = rd_data_r;
    assign rd_valid  = rd_valid_r;
    assign done      = done_r;
    assign status    = status_r;
    assign xfer_cnt  = xfer_r;

endmodule

// File: tb/tb_pci_dac_initiator.sv
// Randomised bench for pci_dac_initiator: a reactive PCI target plus a
// transaction-level model predicting address phases, data, status and count.
module tb_pci_dac_initiator;

    localparam int DEVSEL_TIMEOUT = 5;
    localparam int MAX_LEN        = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req_valid, req_ready, req_write;
    logic [63:0]  req_addr;
    logic [2:0]   req_len;
    logic [127:0] req_wdata;
    logic [3:0]   req_be;
    logic [31:0]  rd_data;
    logic         rd_valid, done;
    logic [1:0]   status;
    logic [2:0]   xfer_cnt;
    logic         FRAMEn, IRDYn;
    logic [3:0]   C_BEn;
    wire  [31:0]  AD;
    logic         TRDYn, STOPn, DEVSELn;
    logic         tb_ad_oe;
    logic [31:0]  tb_ad;

    int n_checks = 0;
    int n_fail   = 0;
    int waits[4];

    assign AD = tb_ad_oe ? tb_ad : 32'bz;

    always #5 CLK = ~CLK;

    pci_dac_initiator #(.DEVSEL_TIMEOUT(DEVSEL_TIMEOUT), .MAX_LEN(MAX_LEN)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_wdata(req_wdata), .req_be(req_be), .rd_data(rd_data),
        .rd_valid(rd_valid), .done(done), .status(status), .xfer_cnt(xfer_cnt),
        .FRAMEn(FRAMEn), .IRDYn(IRDYn), .C_BEn(C_BEn), .AD(AD),
        .TRDYn(TRDYn), .STOPn(STOPn), .DEVSELn(DEVSELn)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dw(input logic [127:0] d, input int k);
        return d[k*32 +: 32];
    endfunction

    task automatic target_idle();
        TRDYn = 1'b1; STOPn = 1'b1; DEVSELn = 1'b1; tb_ad_oe = 1'b0;
    endtask

    // One request end to end; dev=0 means no target claims it, stop_ph<0 means no STOP
    task automatic run_txn(input bit wr, input logic [63:0] addr, input logic [2:0] len,
                           input logic [127:0] wd, input logic [3:0] be,
                           input logic [127:0] rdd, input bit dev, input int stop_ph);
        logic [35:0] exp_ap[$];
        logic [35:0] got_ap[$];
        logic [31:0] got_rd[$];
        logic [3:0]  cmd;
        logic [1:0]  exp_st, got_st;
        logic [2:0]  got_xf;
        bit bad, stop_done, done_seen, busy_ready;
        int n_a, exp_xf, exp_lat, irdy_idx, tph, pw, c, ph;
        bad = (len == 3'd0) || (int'(len) > MAX_LEN);
        cmd = wr ? 4'b0111 : 4'b0110;
        if (!bad) begin
            if (addr[63:32] != 32'd0) begin
                exp_ap.push_back({4'b1101, addr[31:2], 2'b00});
                exp_ap.push_back({cmd, addr[63:32]});
            end else begin
                exp_ap.push_back({cmd, addr[31:2], 2'b00});
            end
        end
        n_a = exp_ap.size();
        exp_lat = 0;
        if (bad) begin
            exp_st = 2'd3; exp_xf = 0; exp_lat = 1;
        end else if (!dev) begin
            exp_st = 2'd2; exp_xf = 0; exp_lat = n_a + DEVSEL_TIMEOUT + 2;
        end else if (stop_ph >= 0 && stop_ph < int'(len) - 1) begin
            exp_st = 2'd1; exp_xf = stop_ph + 1;
        end else begin
            exp_st = 2'd0; exp_xf = int'(len);
        end

        for (int i = 0; i < 20 && !req_ready; i++) @(negedge CLK);
        check_eq("ready_before_req", req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_len = len;
        req_wdata = wd; req_be = be;
        @(negedge CLK);
        req_valid = 1'b0;

        irdy_idx = 0; tph = 0; pw = 0; c = 0;
        stop_done = 0; done_seen = 0; busy_ready = 0;
        got_st = 2'd0; got_xf = 3'd0;
        while (!done_seen && c < 100) begin
            c++;
            if (req_ready) busy_ready = 1;
            if (rd_valid) got_rd.push_back(rd_data);
            if (done) begin
                done_seen = 1;
                got_st = status;
                got_xf = xfer_cnt;
                target_idle();
            end else if (!IRDYn) begin
                irdy_idx++;
                if (!wr && irdy_idx == 1) begin
                    TRDYn = 1'b1; STOPn = 1'b1; DEVSELn = !dev;
                    tb_ad = 32'd0; tb_ad_oe = 1'b1;
                    #1 check_eq("turn_ad_released", AD, 32'd0);
                end else if (stop_done || !dev || tph >= int'(len)) begin
                    TRDYn = 1'b1; STOPn = 1'b1; tb_ad_oe = 1'b0;
                end else begin
                    DEVSELn = 1'b0;
                    ph = tph;
                    if (pw < waits[tph]) begin
                        pw++;
                        TRDYn = 1'b1; STOPn = 1'b1;
                    end else begin
                        TRDYn = 1'b0;
                        STOPn = (tph == stop_ph) ? 1'b0 : 1'b1;
                        check_eq("data_cbe", C_BEn, be);
                        check_eq("data_frame", FRAMEn, (tph == int'(len) - 1));
                        if (wr) check_eq("wr_data", AD, dw(wd, tph));
                        if (tph == stop_ph) stop_done = 1;
                        pw = 0;
                        tph++;
                    end
                    if (!wr) begin
                        tb_ad = dw(rdd, ph); tb_ad_oe = 1'b1;
                    end else begin
                        tb_ad_oe = 1'b0;
                    end
                end
            end else begin
                target_idle();
                if (!FRAMEn) got_ap.push_back({C_BEn, AD});
            end
            if (!done_seen) @(negedge CLK);
        end

        check_eq("done_seen", done_seen, 1'b1);
        check_eq("status", got_st, exp_st);
        check_eq("xfer_cnt", got_xf, exp_xf[2:0]);
        check_eq("ready_low_busy", busy_ready, 1'b0);
        if (exp_lat > 0) check_eq("done_latency", c, exp_lat);
        check_eq("addr_phase_cnt", got_ap.size(), n_a);
        for (int i = 0; i < n_a && i < got_ap.size(); i++)
            check_eq("addr_phase", got_ap[i], exp_ap[i]);
        check_eq("rd_cnt", got_rd.size(), wr ? 0 : exp_xf);
        for (int i = 0; i < got_rd.size() && !wr && i < exp_xf; i++)
            check_eq("rd_data", got_rd[i], dw(rdd, i));
        @(negedge CLK);
        check_eq("done_pulse_end", done, 1'b0);
        check_eq("ready_after_end", req_ready, 1'b1);
    endtask

    task automatic set_waits(input int a, input int b, input int c2, input int d);
        waits[0] = a; waits[1] = b; waits[2] = c2; waits[3] = d;
    endtask

    initial begin
        logic [63:0]  a;
        logic [127:0] wd, rdd;
        logic [2:0]   ln;
        int sp;
        bit dv;
        RST = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 64'd0; req_len = 3'd0;
        req_wdata = 128'd0; req_be = 4'h0; tb_ad = 32'd0;
        target_idle();
        set_waits(0, 0, 0, 0);
        repeat (3) @(negedge CLK);
        check_eq("rst_frame", FRAMEn, 1'b1);
        check_eq("rst_irdy", IRDYn, 1'b1);
        check_eq("rst_cbe", C_BEn, 4'hF);
        check_eq("rst_ready", req_ready, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_rd_valid", rd_valid, 1'b0);
        check_eq("rst_status", status, 2'd0);
        check_eq("rst_xfer", xfer_cnt, 3'd0);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("ready_after_rst", req_ready, 1'b1);

        wd = {32'h88888888, 32'h66666666, 32'h44444444, 32'h22222222};
        run_txn(1'b1, 64'h1111222233330000, 3'd4, wd, 4'h0, 128'd0, 1'b1, -1);
        set_waits(0, 1, 0, 0);
        rdd = {$urandom, $urandom, $urandom, $urandom};
        run_txn(1'b0, 64'h1111222233330000, 3'd4, 128'd0, 4'h3, rdd, 1'b1, -1);
        set_waits(0, 0, 0, 0);
        run_txn(1'b1, 64'h0000000000001000, 3'd1, 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D, 4'h0, 128'd0, 1'b1, -1);
        run_txn(1'b1, 64'h0000000500000040, 3'd2, wd, 4'h0, 128'd0, 1'b0, -1);
        run_txn(1'b0, 64'h0000000000000200, 3'd3, 128'd0, 4'h0, rdd, 1'b0, -1);
        run_txn(1'b0, 64'h1111222233330000, 3'd4, 128'd0, 4'h0, rdd, 1'b1, 1);
        run_txn(1'b1, 64'h0000000000000300, 3'd0, wd, 4'h0, 128'd0, 1'b1, -1);
        run_txn(1'b0, 64'hABCD000000000300, 3'd5, 128'd0, 4'h0, rdd, 1'b1, -1);

        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) a[63:32] = 32'd0;
            ln = 3'($urandom_range(1, MAX_LEN));
            if ($urandom_range(0, 7) == 0) ln = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(5, 7));
            dv = ($urandom_range(0, 5) != 0);
            sp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            set_waits($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            wd  = {$urandom, $urandom, $urandom, $urandom};
            rdd = {$urandom, $urandom, $urandom, $urandom};
            run_txn(1'($urandom_range(0, 1)), a, ln, wd, 4'($urandom_range(0, 15)), rdd, dv, sp);
        end

        // Reset in the middle of a write burst held in wait states
        run_txn(1'b1, 64'h0000000000000400, 3'd7, wd, 4'h0, 128'd0, 1'b1, -1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h0000000700000000;
        req_len = 3'd4; req_wdata = {4{32'hFFFF_FFFF}}; req_be = 4'h5;
        @(negedge CLK);
        req_valid = 1'b0;
        DEVSELn = 1'b0; TRDYn = 1'b1; STOPn = 1'b1;
        for (int i = 0; i < 20 && IRDYn; i++) @(negedge CLK);
        check_eq("mid_rst_in_data", IRDYn, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_frame", FRAMEn, 1'b1);
        check_eq("mid_rst_irdy", IRDYn, 1'b1);
        check_eq("mid_rst_cbe", C_BEn, 4'hF);
        check_eq("mid_rst_ready", req_ready, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_eq("mid_rst_status", status, 2'd0);
        tb_ad = 32'd0; tb_ad_oe = 1'b1;
        #1 check_eq("mid_rst_ad_released", AD, 32'd0);
        target_idle();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check_eq("mid_rst_ready_after", req_ready, 1'b1);
        check_eq("mid_rst_no_done", done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
